// File: rtl/metastable_sampler.sv
// Samples an asynchronous metastable bit, debiases it with a von Neumann pair
// extractor and packs bits into words. Optional repetition health test: METASTABLE_SAMPLER_HEALTH_EN.
module metastable_sampler #(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_DIV   = 4,
  parameter int REPEAT_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             metastable,
  input  logic             enable,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {EMPTY = 1'b0, HAVE_A = 1'b1} pair_state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   raw;
  logic [DIV_W-1:0]       div_reg;
  logic                   strobe;
  pair_state_t            state_reg;
  logic                   a_reg;
  logic [WIDTH-1:0]       shift_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   emit;
  logic                   full;
  logic                   load;
  logic                   load_block;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_reg <= '0;
    else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], metastable};
  end

  assign raw    = sync_reg[SYNC_STAGES-1];
  assign strobe = enable && (div_reg == DIV_W'(SAMPLE_DIV - 1));
  assign emit   = strobe && (state_reg == HAVE_A) && (a_reg != raw);
  assign full   = (cnt_reg == CNT_W'(WIDTH));
  assign load   = full && (!out_valid || out_ready) && !load_block;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) div_reg <= '0;
    else if (strobe)       div_reg <= '0;
    else                   div_reg <= div_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      a_reg     <= 1'b0;
      shift_reg <= '0;
      cnt_reg   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (!enable) begin
        state_reg <= EMPTY;
      end else if (strobe) begin
        case (state_reg)
          EMPTY: begin
            a_reg     <= raw;
            state_reg <= HAVE_A;
          end
          default: state_reg <= EMPTY;
        endcase
      end

      // A full accumulator swallows new bits until its word moves to the output.
      if (load) begin
        out_data  <= shift_reg;
        out_valid <= 1'b1;
        cnt_reg   <= '0;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (emit && !full) begin
          shift_reg <= (shift_reg << 1) | WIDTH'(a_reg);
          cnt_reg   <= cnt_reg + 1'b1;
        end
      end
    end
  end

`ifdef METASTABLE_SAMPLER_HEALTH_EN
  localparam int REP_W = $clog2(REPEAT_LIMIT + 1);

  logic [REP_W-1:0] rep_reg;
  logic [REP_W-1:0] rep_next;
  logic             last_raw_reg;
  logic             fail_reg;

  always_comb begin
    rep_next = REP_W'(1);
    if (rep_reg != '0 && raw == last_raw_reg) begin
      if (rep_reg == REP_W'(REPEAT_LIMIT)) rep_next = rep_reg;
      else                                 rep_next = rep_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_reg      <= '0;
      last_raw_reg <= 1'b0;
      fail_reg     <= 1'b0;
    end else if (strobe) begin
      rep_reg      <= rep_next;
      last_raw_reg <= raw;
      if (rep_next == REP_W'(REPEAT_LIMIT)) fail_reg <= 1'b1;
    end
  end

  assign health_fail = fail_reg;
  assign load_block  = fail_reg;
`else
  assign health_fail = 1'b0;
  assign load_block  = 1'b0;
`endif

endmodule

// File: tb/tb_metastable_sampler.sv
// Scoreboard bench for metastable_sampler: pair-level reference model feeds an
// expected-word queue; a negedge monitor compares every presented word.
module tb_metastable_sampler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       metastable = 1'b0;
  logic       enable = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       health_fail;

  always #5 clk = ~clk;

  metastable_sampler #(
    .WIDTH(8), .SYNC_STAGES(2), .SAMPLE_DIV(1), .REPEAT_LIMIT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .metastable(metastable), .enable(enable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .health_fail(health_fail)
  );

  bit         stim_q[$];
  logic [7:0] exp_q[$];
  bit         run = 1'b0;
  int         arm = 3;
  bit         fill_val = 1'b0;

  // reference model state: bits extracted from pairs, packed MSB-first
  logic [7:0] acc = 8'h00;
  int         nbits = 0;
  bit         hf = 1'b0;
  bit         drop = 1'b0;

  int         checks = 0;
  int         errors = 0;
  bit         probe_req = 1'b0;
  int         probe_sel = 0;
  logic [7:0] probe_exp = 8'h00;
  string      probe_name = "";
  logic [7:0] act;

  int         ready_mode = 0;
  bit         ready_force = 1'b1;
  int         lows = 0;

  // Raw-bit driver; the stream is raised two cycles ahead of enable so the
  // first enabled sample is the first queued bit. Idle filler is equal pairs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!run) begin
        enable     = 1'b0;
        arm        = 3;
        metastable = ~metastable;
      end else begin
        if (stim_q.size() == 0) begin
          stim_q.push_back(fill_val);
          stim_q.push_back(fill_val);
          fill_val = ~fill_val;
        end
        metastable = stim_q.pop_front();
        if (arm > 0) begin
          arm = arm - 1;
          if (arm == 0) enable = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        out_ready = ready_force;
      end else if (lows >= 5 || $urandom_range(0, 3) != 0) begin
        out_ready = 1'b1;
        lows = 0;
      end else begin
        out_ready = 1'b0;
        lows = lows + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected got %h want none", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL word_data got %h want %h", out_data, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (probe_req) begin
      case (probe_sel)
        0:       act = {7'b0, out_valid};
        1:       act = out_data;
        2:       act = {7'b0, health_fail};
        default: act = 8'(exp_q.size());
      endcase
      checks++;
      if (act !== probe_exp) begin
        errors++;
        $display("FAIL %s got %h want %h", probe_name, act, probe_exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic probe(input string nm, input int sel, input logic [7:0] e);
    probe_name = nm;
    probe_sel  = sel;
    probe_exp  = e;
    probe_req  = 1'b1;
    @(negedge clk);
    #1 probe_req = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic model_bit(input bit v);
    if (!drop) begin
      acc   = {acc[6:0], v};
      nbits = nbits + 1;
      if (nbits == 8) begin
        if (!hf) exp_q.push_back(acc);
        nbits = 0;
      end
    end
  endtask

  task automatic push_pair(input bit a, input bit b);
    stim_q.push_back(a);
    stim_q.push_back(b);
    if (a != b) model_bit(a);
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) push_pair(v[i], !v[i]);
  endtask

  task automatic drain();
    int b = 0;
    while (stim_q.size() != 0 && b < 5000) begin
      tick(1);
      b++;
    end
    tick(6);
  endtask

  task automatic do_reset();
    run = 1'b0;
    stim_q.delete();
    exp_q.delete();
    acc = 8'h00;
    nbits = 0;
    hf = 1'b0;
    drop = 1'b0;
    rst_n = 1'b0;
    tick(1);
    probe("rst_valid", 0, 8'h00);
    probe("rst_data", 1, 8'h00);
    probe("rst_health", 2, 8'h00);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] wa;
    logic [7:0] wb;
    logic [19:0] seq3;
    int b;

    tick(1);
    do_reset();

    // all-ones then all-zeros words; first word latency SYNC+2*WIDTH+1
    for (int i = 0; i < 8; i++) push_pair(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) push_pair(1'b0, 1'b1);
    run = 1'b1;
    tick(19);
    probe("latency_not_yet", 0, 8'h00);
    probe("latency_valid", 0, 8'h01);
    drain();
    probe("zeros_word", 1, 8'h00);

    // mixed pairs with discards
    seq3 = 20'b10_00_01_11_10_10_01_01_10_01;
    for (int i = 0; i < 10; i++) push_pair(seq3[19-2*i], seq3[18-2*i]);
    drain();
    probe("mixed_word", 1, 8'hB2);

    // backpressure: A held, B fills, extras dropped, release loads B at once
    ready_force = 1'b0;
    tick(2);
    wa = 8'($urandom);
    wb = 8'($urandom);
    push_byte(wa);
    push_byte(wb);
    drain();
    probe("bp_hold_valid", 0, 8'h01);
    probe("bp_hold_data", 1, wa);
    drop = 1'b1;
    for (int i = 0; i < 4; i++) push_pair(1'b1, 1'b0);
    drain();
    drop = 1'b0;
    probe("bp_still_a", 1, wa);
    ready_force = 1'b1;
    tick(2);
    probe("bp_valid_kept", 0, 8'h01);
    probe("bp_b_loaded", 1, wb);
    drain();

    // repetition test: 32 identical samples
    do_reset();
    for (int i = 0; i < 16; i++) push_pair(1'b1, 1'b1);
    run = 1'b1;
    tick(34);
    probe("health_31", 2, 8'h00);
`ifdef METASTABLE_SAMPLER_HEALTH_EN
    probe("health_32", 2, 8'h01);
    hf = 1'b1;
`else
    probe("health_32", 2, 8'h00);
`endif
    push_byte(8'($urandom));
    drain();
    tick(10);
`ifdef METASTABLE_SAMPLER_HEALTH_EN
    probe("health_no_load", 0, 8'h00);
`endif

    // reset after a partial word: the next word is built only from fresh bits
    do_reset();
    for (int i = 0; i < 5; i++) push_pair(1'b1, 1'b0);
    run = 1'b1;
    drain();
    do_reset();
    rb = 8'($urandom);
    push_byte(rb);
    run = 1'b1;
    drain();
    probe("fresh_word", 1, rb);

    // random pairs with random, bounded backpressure
    ready_mode = 1;
    for (int i = 0; i < 300; i++) push_pair(1'($urandom), 1'($urandom));
    drain();
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      tick(1);
      b++;
    end
    ready_mode = 0;
    probe("words_outstanding", 3, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
